// File: rtl/instr_mem_fetch.sv
// Byte-addressed little-endian instruction memory with a loader port and a
// pipelined, credit-limited fetch port (fixed latency, in-order response queue).
module instr_mem_fetch #(
  parameter int SIZE    = 256,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [7:0]        ld_data,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_adr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_adr,
  output logic              rsp_err
);

  localparam int AW = $clog2(SIZE);
  localparam int QD = LATENCY + 1;
  localparam int QW = $clog2(QD);
  localparam int CW = $clog2(QD + 1);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] adr;
    logic              err;
  } ent_t;

  function automatic logic [QW-1:0] f_nxt(input logic [QW-1:0] p);
    return (p == QW'(QD - 1)) ? '0 : p + QW'(1);
  endfunction

  // storage: intentionally not reset so program images survive rst_n
  logic [7:0] r_mem [SIZE];

  always_ff @(posedge clk) begin
    if (ld_en && (ld_adr < ADDR_W'(SIZE)))
      r_mem[ld_adr[AW-1:0]] <= ld_data;
  end

  // fetch sampling and fault classification at the accept edge
  logic [AW-1:0] w_a;
  logic          w_mis, w_oor, w_fault, w_acc;
  logic [31:0]   w_word;
  ent_t          w_new;

  assign w_a     = req_adr[AW-1:0];
  assign w_mis   = (req_adr[1:0] != 2'b00);
  assign w_oor   = (req_adr > ADDR_W'(SIZE - 4));
  assign w_fault = w_mis || w_oor;
  assign w_word  = {r_mem[w_a + AW'(3)], r_mem[w_a + AW'(2)],
                    r_mem[w_a + AW'(1)], r_mem[w_a]};
  assign w_new.instr = w_fault ? 32'h0 : w_word;
  assign w_new.adr   = req_adr;
  assign w_new.err   = w_fault;

  // latency pipeline
  logic [LATENCY-1:0] r_vld_pipe;
  ent_t               r_pd [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else if (flush) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_acc;
      for (int i = 1; i < LATENCY; i++)
        r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_pd[0] <= w_new;
    for (int i = 1; i < LATENCY; i++)
      r_pd[i] <= r_pd[i-1];
  end

  // output queue; r_cnt counts pipeline plus queue entries to bound acceptance
  ent_t          r_q [QD];
  logic [QW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_qn, r_cnt;
  logic          w_push, w_pop;
  ent_t          w_out, r_hold;

  assign w_push    = r_vld_pipe[LATENCY-1];
  assign rsp_valid = (r_qn != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign req_ready = rst_n && !ld_en && !flush && (r_cnt < CW'(QD));
  assign w_acc     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (w_push)
      r_q[r_wr] <= r_pd[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_qn  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_qn  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= f_nxt(r_wr);
      if (w_pop)  r_rd <= f_nxt(r_rd);
      r_qn  <= r_qn + CW'(w_push) - CW'(w_pop);
      r_cnt <= r_cnt + CW'(w_acc) - CW'(w_pop);
    end
  end

  // outputs show the head while valid, otherwise the last values presented
  assign w_out = rsp_valid ? r_q[r_rd] : r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold <= '0;
    else        r_hold <= w_out;
  end

  assign rsp_instr = w_out.instr;
  assign rsp_adr   = w_out.adr;
  assign rsp_err   = w_out.err;

endmodule
